// File: rtl/univ_shift_reg.sv
// Universal shift register with an auto-transfer sequencer.
// Manual mode: hold / shift right / shift left / parallel load.
// Auto mode: a start pulse loads d and shifts it out over exactly WIDTH cycles.
// The optional macro SHIFT_ROTATE_EN enables rotate-on-shift, selected by rot.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sir,
  input  logic             sil,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic             dir,
  input  logic             rot,
  output logic [WIDTH-1:0] q,
  output logic             sor,
  output logic             sol,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               busy_q, done_q;
  logic               fill_r, fill_l;
  logic [WIDTH-1:0]   shr, shl;

`ifdef SHIFT_ROTATE_EN
  // With rot set, the bit leaving one end re-enters at the other.
  assign fill_r = rot ? q_q[0]       : sir;
  assign fill_l = rot ? q_q[WIDTH-1] : sil;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign fill_r = sir;
  assign fill_l = sil;
`endif

  assign shr = {fill_r, q_q[WIDTH-1:1]};
  assign shl = {q_q[WIDTH-2:0], fill_l};

  // Next-state logic: start wins over manual mode in IDLE; SHIFT runs WIDTH cycles.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          q_d     = d;
          dir_d   = dir;
          cnt_d   = '0;
          state_d = StShift;
        end else if (en) begin
          case (mode)
            2'b01:   q_d = shr;
            2'b10:   q_d = shl;
            2'b11:   q_d = d;
            default: q_d = q_q;
          endcase
        end
      end
      StShift: begin
        q_d = dir_q ? shl : shr;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, data and status registers; clear wipes everything immediately.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy_q  <= (state_d == StShift);
      done_q  <= (state_d == StDone);
    end
  end

  assign q    = q_q;
  assign sor  = q_q[0];
  assign sol  = q_q[WIDTH-1];
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=4). The stimulus process pushes the
// expected state for each observed cycle; the monitor pops and compares at negedge.
module tb_univ_shift_reg;

  logic       clk;
  logic       clear;
  logic       en;
  logic [1:0] mode;
  logic       sir;
  logic       sil;
  logic [3:0] d;
  logic       start;
  logic       dir;
  logic       rot;
  logic [3:0] q;
  logic       sor;
  logic       sol;
  logic       busy;
  logic       done;

  univ_shift_reg #(.WIDTH(4)) dut (
    .clk   (clk),
    .clear (clear),
    .en    (en),
    .mode  (mode),
    .sir   (sir),
    .sil   (sil),
    .d     (d),
    .start (start),
    .dir   (dir),
    .rot   (rot),
    .q     (q),
    .sor   (sor),
    .sol   (sol),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       chk_ser;
    logic       left;
    logic       ser;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [3:0] eq, input logic eb, input logic ed);
    exp_t e;
    e.name = name; e.q = eq; e.busy = eb; e.done = ed;
    e.chk_ser = 1'b0; e.left = 1'b0; e.ser = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic chk_s(input string name, input logic [3:0] eq, input logic left,
                       input logic ser);
    exp_t e;
    e.name = name; e.q = eq; e.busy = 1'b1; e.done = 1'b0;
    e.chk_ser = 1'b1; e.left = left; e.ser = ser;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the expectation pushed this cycle against the DUT.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic s;
      e = exp_q.pop_front();
      n_tests++;
      if (q !== e.q) begin
        n_fail++;
        $display("FAIL %s q: got %b want %b", e.name, q, e.q);
      end
      n_tests++;
      if (busy !== e.busy || done !== e.done) begin
        n_fail++;
        $display("FAIL %s busy/done: got %b/%b want %b/%b", e.name, busy, done, e.busy,
                 e.done);
      end
      if (e.chk_ser) begin
        s = e.left ? sol : sor;
        n_tests++;
        if (s !== e.ser) begin
          n_fail++;
          $display("FAIL %s serial: got %b want %b", e.name, s, e.ser);
        end
      end
    end
  end

  initial begin
    clear = 1'b0; en = 1'b0; mode = 2'b00; sir = 1'b0; sil = 1'b0;
    d = 4'b0000; start = 1'b0; dir = 1'b0; rot = 1'b0;

    tick();
    chk("reset", 4'b0000, 1'b0, 1'b0);
    clear = 1'b1;

    // Manual load, right shift, left shift
    en = 1'b1; mode = 2'b11; d = 4'b1011;
    tick(); chk("load", 4'b1011, 1'b0, 1'b0);
    mode = 2'b01; sir = 1'b0;
    tick(); chk("shr", 4'b0101, 1'b0, 1'b0);
    mode = 2'b10; sil = 1'b1;
    tick(); chk("shl", 4'b1011, 1'b0, 1'b0);

    // en=0 holds despite mode=11
    en = 1'b0; mode = 2'b11; d = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("hold", 4'b1011, 1'b0, 1'b0);
    end

    // start beats en/mode; right transfer of 0110 with sir=0
    start = 1'b1; en = 1'b1; mode = 2'b11; dir = 1'b0; sir = 1'b0;
    tick(); chk_s("prio c0", 4'b0110, 1'b0, 1'b0);
    start = 1'b0; en = 1'b0;
    tick(); chk_s("prio c1", 4'b0011, 1'b0, 1'b1);
    tick(); chk_s("prio c2", 4'b0001, 1'b0, 1'b1);
    tick(); chk_s("prio c3", 4'b0000, 1'b0, 1'b0);
    tick(); chk("prio done", 4'b0000, 1'b0, 1'b1);
    tick(); chk("prio idle", 4'b0000, 1'b0, 1'b0);

    // Right transfer of 1101, sir=1: sor = 1,0,1,1, final 1111
    d = 4'b1101; dir = 1'b0; sir = 1'b1; start = 1'b1;
    tick(); chk_s("xr c0", 4'b1101, 1'b0, 1'b1);
    start = 1'b0;
    tick(); chk_s("xr c1", 4'b1110, 1'b0, 1'b0);
    tick(); chk_s("xr c2", 4'b1111, 1'b0, 1'b1);
    tick(); chk_s("xr c3", 4'b1111, 1'b0, 1'b1);
    // start held high through DONE is ignored there
    start = 1'b1;
    tick(); chk("xr done", 4'b1111, 1'b0, 1'b1);
    tick(); chk("xr idle", 4'b1111, 1'b0, 1'b0);
    // Next IDLE edge accepts it; toggle controls during SHIFT
    tick(); chk_s("tg c0", 4'b1101, 1'b0, 1'b1);
    start = 1'b0; mode = 2'b10; dir = 1'b1; en = 1'b1; d = 4'b0000;
    tick(); chk_s("tg c1", 4'b1110, 1'b0, 1'b0);
    start = 1'b1; mode = 2'b11; dir = 1'b0;
    tick(); chk_s("tg c2", 4'b1111, 1'b0, 1'b1);
    start = 1'b0; mode = 2'b01; dir = 1'b1;
    tick(); chk_s("tg c3", 4'b1111, 1'b0, 1'b1);
    en = 1'b0;
    tick(); chk("tg done", 4'b1111, 1'b0, 1'b1);
    tick(); chk("tg idle", 4'b1111, 1'b0, 1'b0);

    // Left transfer of 1100, sil=1: sol = 1,1,0,0, final 1111
    d = 4'b1100; dir = 1'b1; sil = 1'b1; start = 1'b1;
    tick(); chk_s("xl c0", 4'b1100, 1'b1, 1'b1);
    start = 1'b0; dir = 1'b0;
    tick(); chk_s("xl c1", 4'b1001, 1'b1, 1'b1);
    tick(); chk_s("xl c2", 4'b0011, 1'b1, 1'b0);
    tick(); chk_s("xl c3", 4'b0111, 1'b1, 1'b0);
    tick(); chk("xl done", 4'b1111, 1'b0, 1'b1);
    tick(); chk("xl idle", 4'b1111, 1'b0, 1'b0);

    // Asynchronous clear in SHIFT cycle 1, between edges
    d = 4'b1011; dir = 1'b0; sir = 1'b0; start = 1'b1;
    tick(); chk_s("clr c0", 4'b1011, 1'b0, 1'b1);
    start = 1'b0;
    tick();
    #1 clear = 1'b0;
    chk("clr async", 4'b0000, 1'b0, 1'b0);
    #4 clear = 1'b1;
    tick(); chk("clr idle", 4'b0000, 1'b0, 1'b0);

    // Manual right shift with rot=1
    en = 1'b1; mode = 2'b11; d = 4'b1000;
    tick(); chk("rot load", 4'b1000, 1'b0, 1'b0);
    mode = 2'b01; sir = 1'b0; rot = 1'b1;
    tick(); chk("rot s1", 4'b0100, 1'b0, 1'b0);
    tick(); chk("rot s2", 4'b0010, 1'b0, 1'b0);
    tick(); chk("rot s3", 4'b0001, 1'b0, 1'b0);
`ifdef SHIFT_ROTATE_EN
    tick(); chk("rot s4", 4'b1000, 1'b0, 1'b0);
`else
    tick(); chk("rot s4", 4'b0000, 1'b0, 1'b0);
`endif
    en = 1'b0; rot = 1'b0;

    tick();
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
